// File: rtl/dma_copy_engine_pkg.sv
// Shared types for the DMA copy engine: FSM state encoding and address stride helper.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } dma_copy_state_e;

  localparam int unsigned DMA_DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DMA_DEFAULT_ADDR_WIDTH = 32;

  // Agent command at the default widths; the engine builds its own copy at its parameterised widths.
  typedef struct packed {
    logic                              start;
    logic                              we;
    logic [DMA_DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DMA_DEFAULT_DATA_WIDTH-1:0] wdata;
  } dma_agt_cmd_t;

  function automatic int unsigned stride_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dma_copy_engine_if.sv
// Control/response bundle between the copy engine (master) and the Wishbone agent (slave).
interface dma_copy_engine_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  start;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output start, we, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, we, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-copy sequencer driving a single-transaction agent with alternating reads and writes.
// Optional abort input enabled by defining DMA_COPY_ABORT_EN.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_go,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
`ifdef DMA_COPY_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic [LEN_WIDTH-1:0]  o_words_done,
  dma_copy_engine_if.master     agt
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(stride_bytes(DATA_WIDTH));

  typedef struct packed {
    logic                  start;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } agt_cmd_t;

  dma_copy_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  agt_cmd_t              cmd_q, cmd_d;
  logic                  abort_q, abort_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_in;

`ifdef DMA_COPY_ABORT_EN
  assign abort_in = i_abort;
`else
  assign abort_in = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      buf_q   <= '0;
      cmd_q   <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      buf_q   <= buf_d;
      cmd_q   <= cmd_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    words_d   = words_q;
    buf_d     = buf_q;
    cmd_d     = cmd_q;
    cmd_d.start = 1'b0;
    abort_d   = abort_q;

    // A same-cycle abort request takes effect immediately, not one cycle later.
    if (state_q != ST_IDLE && abort_in) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_go) begin
          src_d   = i_src_addr;
          dst_d   = i_dst_addr;
          rem_d   = i_len;
          words_d = '0;
          state_d = (i_len == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (abort_d) begin
          state_d = ST_DONE;
        end else if (!agt.busy) begin
          cmd_d.start = 1'b1;
          cmd_d.we    = 1'b0;
          cmd_d.addr  = src_q;
          state_d     = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (agt.done) begin
          if (abort_d) begin
            state_d = ST_DONE;
          end else begin
            buf_d   = agt.rdata;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (!agt.busy) begin
          cmd_d.start = 1'b1;
          cmd_d.we    = 1'b1;
          cmd_d.addr  = dst_q;
          cmd_d.wdata = buf_q;
          state_d     = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (agt.done) begin
          src_d   = src_q + STRIDE;
          dst_d   = dst_q + STRIDE;
          rem_d   = rem_q - LEN_WIDTH'(1);
          words_d = words_q + LEN_WIDTH'(1);
          state_d = (abort_d || rem_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) abort_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_words_done = words_q;
  assign agt.start    = cmd_q.start;
  assign agt.we       = cmd_q.we;
  assign agt.addr     = cmd_q.addr;
  assign agt.wdata    = cmd_q.wdata;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine with a behavioural agent/slave and a transaction-list reference model.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] src_in = '0;
  logic [31:0] dst_in = '0;
  logic [15:0] len_in = '0;
`ifdef DMA_COPY_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [15:0] words;

  dma_copy_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) agt ();

  dma_copy_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_go         (go),
    .i_src_addr   (src_in),
    .i_dst_addr   (dst_in),
    .i_len        (len_in),
`ifdef DMA_COPY_ABORT_EN
    .i_abort      (abort),
`endif
    .o_busy       (busy),
    .o_done       (done),
    .o_words_done (words),
    .agt          (agt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];
  int   start_cyc_q[$];
  int   cyc = 0;
  int   go_cyc = 0;
  int   ws = 0;
  int   force_busy = 0;
  int   proto_err = 0;
  int   passed = 0;
  int   total = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: a copy of n words is R(src+4i), W(dst+4i, mem[src+4i]) for i = 0..n-1.
  function automatic void build_expected(input logic [31:0] s, input logic [31:0] d, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{we: 1'b0, addr: s + 32'(4 * i), data: 32'h0});
      exp_q.push_back('{we: 1'b1, addr: d + 32'(4 * i), data: mem_rd(s + 32'(4 * i))});
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Agent/slave: done arrives ws cycles after the start cycle's successor; rdata is junk outside done.
  initial begin
    logic pend;
    int   cnt;
    txn_t cur;
    pend = 1'b0; cnt = 0; cur = '0;
    agt.busy = 1'b0; agt.done = 1'b0; agt.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      agt.done  = 1'b0;
      agt.rdata = $urandom;
      if (!rst_n) begin
        pend = 1'b0;
        agt.busy = 1'b0;
      end else begin
        if (pend) begin
          if (agt.we !== cur.we || agt.addr !== cur.addr || (cur.we && agt.wdata !== cur.data)) proto_err++;
          if (agt.start) proto_err++;
          if (cnt == 0) begin
            agt.done = 1'b1;
            pend = 1'b0;
            if (!cur.we) agt.rdata = mem_rd(cur.addr);
          end else begin
            cnt--;
            agt.busy = 1'b1;
          end
        end else if (agt.start) begin
          if (agt.busy) proto_err++;
          cur = '{we: agt.we, addr: agt.addr, data: agt.we ? agt.wdata : 32'h0};
          log_q.push_back(cur);
          start_cyc_q.push_back(cyc);
          pend = 1'b1;
          cnt = ws;
        end
        if (!pend) agt.busy = (force_busy > 0);
        if (force_busy > 0) force_busy--;
      end
    end
  end

  // Issues one job and follows it to the cycle after o_done; called at posedge+2.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int w, input int pre_busy, input bit regos,
                         output int done_rel, output int done_pulses, output int busy_cycles);
    ws = w;
    proto_err = 0;
    log_q.delete();
    start_cyc_q.delete();
    src_in = s; dst_in = d; len_in = n; go = 1'b1;
    go_cyc = cyc;
    force_busy = pre_busy;
    done_rel = -1; done_pulses = 0; busy_cycles = 0;
    @(posedge clk);
    #2;
    src_in = $urandom; dst_in = $urandom; len_in = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_rel < 0) done_rel = cyc - go_cyc;
      end
      if (done_rel >= 0 && cyc - go_cyc >= done_rel + 1) break;
      go = (regos && (cyc - go_cyc == 3));
      @(posedge clk);
      #2;
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({busy, done, words} !== 18'h0) $display("FAIL reset_status: busy=%0d done=%0d words=%0d, expected all 0", busy, done, words);
    else passed++;
    total++;
    if ({agt.start, agt.we, agt.addr, agt.wdata} !== 66'h0)
      $display("FAIL reset_agent_cmd: start=%0d we=%0d addr=%h wdata=%h, expected all 0", agt.start, agt.we, agt.addr, agt.wdata);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_single_word();
    int dr, dp, bc;
    run_job(32'h1000, 32'h2000, 16'd1, 0, 0, 1'b0, dr, dp, bc);
    build_expected(32'h1000, 32'h2000, 1);
    total++;
    if (dr !== 7) $display("FAIL single_done_cycle: got %0d, expected 7", dr); else passed++;
    total++;
    if (log_q.size() !== 2) $display("FAIL single_txn_count: got %0d, expected 2", log_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL single_txn[%0d]: got we=%0d addr=%h data=%h, expected we=%0d addr=%h data=%h",
                 i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      else passed++;
    end
    total++;
    if (words !== 16'd1) $display("FAIL single_words_done: got %0d, expected 1", words); else passed++;
    total++;
    if (dp !== 1 || proto_err !== 0) $display("FAIL single_protocol: done_pulses=%0d proto_err=%0d, expected 1 and 0", dp, proto_err);
    else passed++;
  endtask

  task automatic test_wait_states();
    int dr, dp, bc;
    run_job(32'h100, 32'h800, 16'd4, 3, 0, 1'b0, dr, dp, bc);
    build_expected(32'h100, 32'h800, 4);
    total++;
    if (log_q.size() !== 8) $display("FAIL wait_txn_count: got %0d, expected 8", log_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL wait_txn[%0d]: got we=%0d addr=%h data=%h, expected we=%0d addr=%h data=%h",
                 i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      else passed++;
    end
    total++;
    if (words !== 16'd4) $display("FAIL wait_words_done: got %0d, expected 4", words); else passed++;
    total++;
    if (dr !== 12 * 4 + 1) $display("FAIL wait_done_cycle: got %0d, expected %0d", dr, 12 * 4 + 1); else passed++;
    total++;
    if (bc !== dr || proto_err !== 0) $display("FAIL wait_busy_span: busy_cycles=%0d proto_err=%0d, expected %0d and 0", bc, proto_err, dr);
    else passed++;
  endtask

  task automatic test_zero_len();
    int dr, dp, bc;
    run_job(32'h3000, 32'h4000, 16'd0, 0, 0, 1'b0, dr, dp, bc);
    total++;
    if (dr !== 1) $display("FAIL zero_done_cycle: got %0d, expected 1", dr); else passed++;
    total++;
    if (log_q.size() !== 0) $display("FAIL zero_no_bus: got %0d transactions, expected 0", log_q.size()); else passed++;
    total++;
    if (bc !== 1) $display("FAIL zero_busy_cycles: got %0d, expected 1", bc); else passed++;
    total++;
    if (words !== 16'd0) $display("FAIL zero_words_done: got %0d, expected 0", words); else passed++;
  endtask

  task automatic test_wrap();
    int dr, dp, bc;
    logic [31:0] d;
    d = $urandom & 32'hFFFF_FFFC;
    run_job(32'hFFFF_FFFC, d, 16'd2, 1, 0, 1'b0, dr, dp, bc);
    build_expected(32'hFFFF_FFFC, d, 2);
    total++;
    if (log_q.size() !== 4) $display("FAIL wrap_txn_count: got %0d, expected 4", log_q.size());
    else if (log_q[2].addr !== 32'h0) $display("FAIL wrap_second_read: got %h, expected 00000000", log_q[2].addr);
    else passed++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL wrap_txn[%0d]: got we=%0d addr=%h data=%h, expected we=%0d addr=%h data=%h",
                 i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      else passed++;
    end
  endtask

  task automatic test_busy_and_rego();
    int dr, dp, bc;
    run_job(32'h0000_A000, 32'h0000_B000, 16'd3, 1, 5, 1'b1, dr, dp, bc);
    build_expected(32'h0000_A000, 32'h0000_B000, 3);
    total++;
    if (start_cyc_q.size() == 0 || start_cyc_q[0] - go_cyc !== 7)
      $display("FAIL busy_first_start: got cycle %0d, expected 7", start_cyc_q.size() ? start_cyc_q[0] - go_cyc : -1);
    else passed++;
    total++;
    if (log_q.size() !== 6 || proto_err !== 0)
      $display("FAIL busy_no_double_start: txns=%0d proto_err=%0d, expected 6 and 0", log_q.size(), proto_err);
    else passed++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL rego_txn[%0d]: got we=%0d addr=%h data=%h, expected we=%0d addr=%h data=%h",
                 i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      else passed++;
    end
    total++;
    if (dr !== 8 * 3 + 1 + 5 || words !== 16'd3) $display("FAIL rego_completion: done_cycle=%0d words=%0d, expected 30 and 3", dr, words);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int dr, dp, bc, n, w;
    logic [31:0] s, d;
    for (int j = 0; j < 6; j++) begin
      s = $urandom; d = $urandom;
      n = $urandom_range(1, 5); w = $urandom_range(0, 3);
      run_job(s, d, 16'(n), w, 0, 1'b0, dr, dp, bc);
      build_expected(s, d, n);
      total++;
      if (dr !== (6 + 2 * w) * n + 1 || dp !== 1)
        $display("FAIL b2b[%0d]_timing: done_cycle=%0d pulses=%0d, expected %0d and 1", j, dr, dp, (6 + 2 * w) * n + 1);
      else passed++;
      total++;
      if (log_q.size() !== exp_q.size() || words !== 16'(n) || proto_err !== 0)
        $display("FAIL b2b[%0d]_counts: txns=%0d words=%0d proto_err=%0d, expected %0d, %0d, 0", j, log_q.size(), words, proto_err, exp_q.size(), n);
      else passed++;
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        total++;
        if (log_q[i] !== exp_q[i])
          $display("FAIL b2b[%0d]_txn[%0d]: got we=%0d addr=%h data=%h, expected we=%0d addr=%h data=%h",
                   j, i, log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int  n_log;
    bit  seen_done, seen_busy;
    ws = 2;
    log_q.delete();
    src_in = 32'h4000; dst_in = 32'h5000; len_in = 16'd4; go = 1'b1;
    @(posedge clk);
    #2;
    go = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if ({busy, done, words, agt.start, agt.we, agt.addr, agt.wdata} !== 84'h0)
      $display("FAIL midreset_outputs: busy=%0d done=%0d words=%0d start=%0d addr=%h, expected all 0", busy, done, words, agt.start, agt.addr);
    else passed++;
    rst_n = 1'b1;
    n_log = log_q.size();
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #2;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    total++;
    if (seen_done || seen_busy || log_q.size() !== n_log)
      $display("FAIL midreset_abandon: done_seen=%0d busy_seen=%0d new_txns=%0d, expected 0 0 0", seen_done, seen_busy, log_q.size() - n_log);
    else passed++;
  endtask

`ifdef DMA_COPY_ABORT_EN
  task automatic test_abort();
    int dr, dp, bc;
    fork
      run_job(32'h0000_6000, 32'h0000_7000, 16'd8, 3, 0, 1'b0, dr, dp, bc);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(posedge clk);
          #2;
          if (log_q.size() == 5) begin
            abort = 1'b1;
            @(posedge clk);
            #2;
            abort = 1'b0;
            break;
          end
        end
      end
    join
    build_expected(32'h0000_6000, 32'h0000_7000, 8);
    total++;
    if (log_q.size() !== 5 || words !== 16'd2 || dp !== 1)
      $display("FAIL abort_partial: txns=%0d words=%0d done_pulses=%0d, expected 5, 2, 1", log_q.size(), words, dp);
    else passed++;
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL abort_txn[%0d]: got we=%0d addr=%h, expected we=%0d addr=%h", i, log_q[i].we, log_q[i].addr, exp_q[i].we, exp_q[i].addr);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_wait_states();
    test_zero_len();
    test_wrap();
    test_busy_and_rego();
    test_back_to_back();
    test_reset_mid_job();
`ifdef DMA_COPY_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Sequencing FSM directly upstream of the team's single-transaction Wishbone master agent.
- On a go command it copies i_len words from a source address to a destination address as alternating single reads and single writes.
- Drives the agent's start/we/addr/wdata control inputs and consumes its busy/done/rdata outputs.
- Sits between the DMA register block (config/go) and the agent.

Parameters:
DATA_WIDTH, 32, word width; address stride = DATA_WIDTH/8
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 16, width of word-count fields

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock, reset is synchronous and active-low
i_go  in  1  start copy; sampled only in IDLE
i_src_addr  in  ADDR_WIDTH  source byte address, latched on go
i_dst_addr  in  ADDR_WIDTH  destination byte address, latched on go
i_len  in  LEN_WIDTH  number of words, latched on go
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle completion pulse
o_words_done  out  LEN_WIDTH  count of completed writes in the current/last job
o_agt_start  out  1  one-cycle start pulse to agent
o_agt_we  out  1  1 = write, 0 = read
o_agt_addr  out  ADDR_WIDTH  transaction address
o_agt_wdata  out  DATA_WIDTH  write data
i_agt_busy  in  1  agent busy
i_agt_done  in  1  agent transaction complete (ack or err)
i_agt_rdata  in  DATA_WIDTH  read data; valid only in the cycle i_agt_done=1 of a read

Behaviour:
- All outputs are registered.
- Reset (i_rst_n=0 at a clock edge) -> state IDLE; every output = 0; data buffer, address and count registers = 0.
- Reset mid-job abandons the job immediately. No o_done is produced.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE + i_go:
  - Latch src, dst and len; clear o_words_done.
  - len==0 -> DONE, with no bus activity.
  - Otherwise -> RD_REQ.
- i_go outside IDLE is ignored.
- RD_REQ:
  - If i_agt_busy=1, hold in RD_REQ with o_agt_start=0.
  - Else assert o_agt_start=1 for exactly one cycle with we=0 and addr=src, then -> RD_WAIT.
- RD_WAIT:
  - On i_agt_done, capture i_agt_rdata into the data buffer, then -> WR_REQ.
  - The data is captured in that cycle only. i_agt_rdata is not valid afterwards.
- WR_REQ: same busy guard as RD_REQ; start for one cycle with we=1, addr=dst, wdata=buffer; -> WR_WAIT.
- WR_WAIT on i_agt_done:
  - src += DATA_WIDTH/8, dst += DATA_WIDTH/8, remaining -= 1, o_words_done += 1.
  - remaining==0 -> DONE, else -> RD_REQ.
- Agent inputs are applied combinationally by the agent, so o_agt_we/addr/wdata hold stable from the start cycle through the done cycle.
- o_agt_start is 0 in every state except the issue cycle.
- DONE: o_done=1 for one cycle -> IDLE.
- An err from the slave is indistinguishable from ack here: the word counts as transferred.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No boundary checking.
- Latency with a zero-wait slave: 6 cycles per word. If i_go is high in cycle 0, o_done is high in cycle 6N+1; for len=0, o_done is high in cycle 1.

Optional Feature:
- Macro DMA_COPY_ABORT_EN.
- Defined:
  - Adds input i_abort (1 bit), which sets a sticky abort flag in any non-IDLE state. The flag clears on entry to IDLE.
  - The in-flight agent transaction always completes; the engine never drops a bus cycle.
  - With the flag set:
    - RD_REQ -> DONE without issuing.
    - RD_WAIT on done -> DONE; the read data is discarded.
    - WR_REQ still issues its write.
    - WR_WAIT on done -> DONE.
  - o_words_done then reports the partial count.
- Undefined: the port is absent; behaviour is as if i_abort=0.

Decomposition:
- Package dma_pkg: state enum dma_copy_state_e; localparam stride helper (DATA_WIDTH/8); agent-command struct {start, we, addr, wdata}.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- len=1, src=0x1000, dst=0x2000, memory[0x1000]=0xDEADBEEF, zero-wait slave -> one read at 0x1000, one write of 0xDEADBEEF at 0x2000, o_done in cycle 7, o_words_done=1.
- len=4, src=0x100, dst=0x800, slave with 3 wait states -> reads at 0x100/104/108/10C, writes at 0x800/804/808/80C with matching data, order R,W,R,W, o_words_done=4.
- len=0 -> o_done in cycle 1, o_agt_start never asserted, o_busy high for exactly one cycle.
- src=0xFFFFFFFC, len=2 -> second read address is 0x00000000 (wrap).
- i_go re-pulsed mid-job, and i_agt_busy held at 1 for 5 cycles in RD_REQ -> the go is ignored; the start is delayed until busy=0, with no double start.
- DMA_COPY_ABORT_EN: len=8, i_abort asserted during word 3's RD_WAIT -> read completes, no write for word 3, o_done pulses, o_words_done=2.
